// File: rtl/cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR/R) between the I- and D-cache.
// One transaction in flight; R beats are steered to the granted cache until RLAST.
module cache_axi_read_arbiter #(
  parameter int         LINE_BEATS = 8,
  parameter logic [3:0] ID_INST    = 4'd0,
  parameter logic [3:0] ID_DATA    = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  input  logic        i_burst,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_rlast,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic        d_arvalid,
  input  logic        d_burst,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_rlast,
  input  logic        d_rready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [3:0]  m_rid,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [7:0] BURST_LEN = 8'(LINE_BEATS - 1);
  localparam logic       GNT_INST  = 1'b0;
  localparam logic       GNT_DATA  = 1'b1;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        burst_q, burst_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        proto_err_q, proto_err_d;
  logic        ar_hs, r_hs, in_data;

  assign m_araddr  = addr_q;
  assign m_arid    = (grant_q == GNT_DATA) ? ID_DATA : ID_INST;
  assign m_arlen   = burst_q ? BURST_LEN : 8'd0;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_arvalid = (state_q == ADDR);
  assign ar_hs     = m_arvalid && m_arready;
  assign i_arready = ar_hs && (grant_q == GNT_INST);
  assign d_arready = ar_hs && (grant_q == GNT_DATA);

  assign in_data   = (state_q == DATA);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign i_rvalid  = in_data && (grant_q == GNT_INST) && m_rvalid;
  assign d_rvalid  = in_data && (grant_q == GNT_DATA) && m_rvalid;
  assign i_rlast   = in_data && (grant_q == GNT_INST) && m_rlast;
  assign d_rlast   = in_data && (grant_q == GNT_DATA) && m_rlast;
  // Outside DATA the R channel is always ready so stray beats are dropped.
  assign m_rready  = !in_data || ((grant_q == GNT_DATA) ? d_rready : i_rready);
  assign r_hs      = in_data && m_rvalid && m_rready;
  assign proto_err = proto_err_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      IDLE: begin
        if (i_arvalid || d_arvalid) begin
          grant_d      = (i_arvalid && d_arvalid) ? ~last_grant_q : d_arvalid;
          last_grant_d = grant_d;
          addr_d       = (grant_d == GNT_DATA) ? d_araddr : i_araddr;
          burst_d      = (grant_d == GNT_DATA) ? d_burst : i_burst;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          beat_cnt_d = 8'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // RLAST must coincide exactly with the beat numbered arlen.
          if ((m_rlast != (beat_cnt_q == m_arlen)) || (m_rid != m_arid))
            proto_err_d = 1'b1;
          if (m_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_DATA;
      burst_q      <= 1'b0;
      addr_q       <= 32'd0;
      beat_cnt_q   <= 8'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Bench for cache_axi_read_arbiter: bench acts as both caches and the AXI slave;
// expectations come from a round-robin/transaction-level model of the port.
module tb_cache_axi_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, m_araddr, m_rdata;
  logic        i_arvalid, i_burst, i_arready, i_rvalid, i_rlast, i_rready;
  logic        d_arvalid, d_burst, d_arready, d_rvalid, d_rlast, d_rready;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, proto_err;

  cache_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_burst(i_burst), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_burst(d_burst), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observations of the most recent transaction served by axi_serve
  logic [31:0] obs_addr;
  logic [3:0]  obs_id;
  logic [7:0]  obs_len;
  logic        obs_irdy, obs_drdy;
  bit          obs_stable, obs_early_rdy;
  int          obs_arv_cyc, obs_rlast_cyc, i_last_idx, d_last_idx;
  logic [31:0] q_i[$], q_d[$], sent[$];

  // Reference model: which side last won arbitration (0 = inst, 1 = data)
  int last_gnt = 1;

  function automatic int pick(input bit ir, input bit dr);
    if (ir && dr) return (last_gnt == 1) ? 0 : 1;
    return ir ? 0 : 1;
  endfunction

  function automatic int qdiff(input logic [31:0] got[$], input logic [31:0] exp[$]);
    int n = 0;
    if (got.size() != exp.size()) return 1000 + got.size();
    foreach (exp[k]) if (got[k] !== exp[k]) n++;
    return n;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_arvalid = 0; d_arvalid = 0; i_burst = 0; d_burst = 0;
    i_araddr = 0; d_araddr = 0; i_rready = 1; d_rready = 1;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    last_gnt = 1;
  endtask

  // AXI slave + cache R sinks for one transaction. Called and returns at a negedge.
  task automatic axi_serve(input int ar_wait, input int nbeats, input int rlast_beat,
                           input bit bad_rid, input bit rnd, input int abort_after);
    int left, b, guard;
    bit gap, done;
    logic [31:0] first_addr;
    obs_stable = 1; obs_early_rdy = 0; i_last_idx = -1; d_last_idx = -1;
    q_i.delete(); q_d.delete(); sent.delete();
    for (int k = 0; k < nbeats; k++) sent.push_back(rnd ? $urandom : 32'h11 * (k + 1));
    m_rvalid = 0; m_rlast = 0;
    m_arready = (ar_wait == 0);
    guard = 0;
    #1;
    while (!m_arvalid && guard < 50) begin
      next_cycle(); guard++; #1;
    end
    if (!m_arvalid) begin
      $display("FAIL ar_timeout: m_arvalid=%0b after %0d cycles, required 1", m_arvalid, guard);
      $fatal(1, "AR timeout");
    end
    obs_arv_cyc = cyc;
    first_addr = m_araddr;
    left = ar_wait;
    while (left > 0) begin
      if (m_araddr !== first_addr || m_arvalid !== 1'b1) obs_stable = 0;
      if (i_arready || d_arready) obs_early_rdy = 1;
      next_cycle(); left--; m_arready = (left == 0); #1;
    end
    if (m_araddr !== first_addr || m_arvalid !== 1'b1) obs_stable = 0;
    obs_addr = m_araddr; obs_id = m_arid; obs_len = m_arlen;
    obs_irdy = i_arready; obs_drdy = d_arready;
    next_cycle();
    m_arready = 0;
    b = 0; guard = 0; done = 0;
    while (!done && guard < 400) begin
      gap = rnd && ($urandom_range(3) == 0);
      i_rready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      d_rready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      m_rvalid = !gap && (b < nbeats);
      m_rdata = 32'h0;
      if (b < nbeats) m_rdata = sent[b];
      m_rlast = (b == rlast_beat);
      m_rid = (bad_rid && b == 0) ? (obs_id ^ 4'h1) : obs_id;
      #1;
      if (i_rvalid && i_rready) begin
        q_i.push_back(i_rdata);
        if (i_rlast) i_last_idx = q_i.size() - 1;
      end
      if (d_rvalid && d_rready) begin
        q_d.push_back(d_rdata);
        if (d_rlast) d_last_idx = q_d.size() - 1;
      end
      if (m_rvalid && m_rready) begin
        if (m_rlast) begin obs_rlast_cyc = cyc; done = 1; end
        b++;
        if (b == abort_after) done = 1;
      end
      next_cycle(); guard++;
    end
    m_rvalid = 0; m_rlast = 0; i_rready = 1; d_rready = 1;
    if (!done) begin
      $display("FAIL r_timeout: beats accepted=%0d, required RLAST within %0d cycles", b, guard);
      $fatal(1, "R timeout");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_arvalid = 1; d_arvalid = 1; m_rvalid = 1; m_rlast = 1; m_arready = 1;
    i_rready = 1; d_rready = 1;
    next_cycle(); next_cycle(); #1;
    checks++;
    if ({m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, m_rready, proto_err} !== 9'b000000010) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000010",
               {m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, m_rready, proto_err});
    end
    checks++;
    if ({m_arsize, m_arburst} !== 5'b010_01) begin
      errors++; $display("FAIL const_size_burst: got %b required 01001", {m_arsize, m_arburst});
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    int t0;
    do_reset();
    i_arvalid = 1; i_burst = 1; i_araddr = 32'hBFC0_0000;
    t0 = cyc;
    axi_serve(0, 8, 7, 0, 0, 0);
    i_arvalid = 0;
    checks++; if (obs_arv_cyc !== t0 + 1) begin errors++; $display("FAIL single_latency: got %0d required %0d", obs_arv_cyc - t0, 1); end
    checks++; if (obs_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_addr: got %h required bfc00000", obs_addr); end
    checks++; if ({obs_id, obs_len} !== {4'd0, 8'd7}) begin errors++; $display("FAIL single_id_len: got id=%0d len=%0d required 0/7", obs_id, obs_len); end
    checks++; if ({obs_irdy, obs_drdy} !== 2'b10) begin errors++; $display("FAIL single_arready: got %b required 10", {obs_irdy, obs_drdy}); end
    checks++; if (qdiff(q_i, sent) != 0) begin errors++; $display("FAIL single_data: got %0d bad beats (size %0d) required 0", qdiff(q_i, sent), q_i.size()); end
    checks++; if (i_last_idx !== 7) begin errors++; $display("FAIL single_rlast: got idx %0d required 7", i_last_idx); end
    checks++; if (q_d.size() !== 0) begin errors++; $display("FAIL single_d_leak: got %0d beats required 0", q_d.size()); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err: got %b required 0", proto_err); end
  endtask

  task automatic test_simultaneous();
    int rl;
    do_reset();
    i_arvalid = 1; i_burst = 1; i_araddr = 32'h0000_1000;
    d_arvalid = 1; d_burst = 1; d_araddr = 32'h0000_2000;
    axi_serve(0, 8, 7, 0, 0, 0);
    i_arvalid = 0;
    rl = obs_rlast_cyc;
    checks++; if (obs_id !== 4'd0) begin errors++; $display("FAIL simul_first_id: got %0d required 0", obs_id); end
    checks++; if (qdiff(q_i, sent) != 0 || q_d.size() != 0) begin errors++; $display("FAIL simul_first_route: got i=%0d d=%0d beats required 8/0", q_i.size(), q_d.size()); end
    axi_serve(0, 8, 7, 0, 0, 0);
    d_arvalid = 0;
    checks++; if (obs_arv_cyc !== rl + 2) begin errors++; $display("FAIL simul_gap: got %0d required 2", obs_arv_cyc - rl); end
    checks++; if ({obs_id, obs_addr} !== {4'd1, 32'h0000_2000}) begin errors++; $display("FAIL simul_second: got id=%0d addr=%h required 1/00002000", obs_id, obs_addr); end
    checks++; if (qdiff(q_d, sent) != 0 || q_i.size() != 0) begin errors++; $display("FAIL simul_second_route: got d=%0d i=%0d beats required 8/0", q_d.size(), q_i.size()); end
  endtask

  task automatic test_fairness();
    int exp;
    do_reset();
    i_arvalid = 1; i_burst = 0; i_araddr = 32'hA000_0000;
    d_arvalid = 1; d_burst = 1; d_araddr = 32'hD000_0000;
    for (int t = 0; t < 4; t++) begin
      exp = pick(1, 1);
      last_gnt = exp;
      axi_serve(0, (exp == 0) ? 1 : 8, (exp == 0) ? 0 : 7, 0, 0, 0);
      checks++;
      if (obs_id !== 4'(exp)) begin errors++; $display("FAIL fair_order[%0d]: got id %0d required %0d", t, obs_id, exp); end
    end
    i_arvalid = 0; d_arvalid = 0;
  endtask

  task automatic test_uncached();
    do_reset();
    d_arvalid = 1; d_burst = 0; d_araddr = 32'hBFAF_F000;
    axi_serve(0, 1, 0, 0, 0, 0);
    d_arvalid = 0;
    checks++; if ({obs_id, obs_len, obs_addr} !== {4'd1, 8'd0, 32'hBFAF_F000}) begin errors++; $display("FAIL uncached_ar: got id=%0d len=%0d addr=%h required 1/0/bfaff000", obs_id, obs_len, obs_addr); end
    checks++; if ({obs_irdy, obs_drdy} !== 2'b01) begin errors++; $display("FAIL uncached_arready: got %b required 01", {obs_irdy, obs_drdy}); end
    checks++; if (qdiff(q_d, sent) != 0 || d_last_idx !== 0 || q_i.size() != 0) begin errors++; $display("FAIL uncached_beat: got d=%0d last=%0d i=%0d required 1/0/0", q_d.size(), d_last_idx, q_i.size()); end
  endtask

  task automatic test_backpressure_err();
    int t0;
    do_reset();
    i_arvalid = 1; i_burst = 1; i_araddr = 32'h1234_5600;
    t0 = cyc;
    axi_serve(5, 8, 2, 0, 0, 0);
    i_arvalid = 0;
    checks++; if (obs_arv_cyc !== t0 + 1) begin errors++; $display("FAIL bp_latency: got %0d required 1", obs_arv_cyc - t0); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b required 1", obs_stable); end
    checks++; if (obs_early_rdy !== 1'b0) begin errors++; $display("FAIL bp_early_arready: got %b required 0", obs_early_rdy); end
    checks++; if (obs_irdy !== 1'b1) begin errors++; $display("FAIL bp_arready: got %b required 1", obs_irdy); end
    checks++; if (q_i.size() !== 3 || i_last_idx !== 2) begin errors++; $display("FAIL bp_early_beats: got %0d last=%0d required 3/2", q_i.size(), i_last_idx); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL early_rlast_err: got %b required 1", proto_err); end
    d_arvalid = 1; d_burst = 0; d_araddr = 32'h0000_0040;
    axi_serve(0, 1, 0, 0, 0, 0);
    d_arvalid = 0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    int bad;
    do_reset();
    i_arvalid = 1; i_burst = 1; i_araddr = 32'h8000_0000;
    axi_serve(0, 8, 7, 0, 0, 4);
    i_arvalid = 0;
    checks++; if (q_i.size() !== 4) begin errors++; $display("FAIL midrst_pre_beats: got %0d required 4", q_i.size()); end
    rst = 1'b1; m_rvalid = 0;
    next_cycle();
    rst = 1'b0;
    m_rvalid = 1; m_rdata = 32'h55; m_rlast = 0; m_rid = 4'd0;
    #1;
    checks++;
    if ({m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, m_rready, proto_err} !== 9'b000000010) begin
      errors++;
      $display("FAIL midrst_outputs: got %b required 000000010",
               {m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, m_rready, proto_err});
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin m_rdata = 32'h55 * (k + 1); m_rlast = (k == 3); #1; end
      if (i_rvalid || d_rvalid || !m_rready) bad++;
      next_cycle();
    end
    m_rvalid = 0; m_rlast = 0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_drain: got %0d leaked/stalled beats required 0", bad); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b required 0", proto_err); end
    d_arvalid = 1; d_burst = 1; d_araddr = 32'h9000_0000;
    axi_serve(0, 8, 7, 0, 0, 0);
    d_arvalid = 0;
    checks++; if (obs_id !== 4'd1 || qdiff(q_d, sent) != 0) begin errors++; $display("FAIL midrst_resume: got id=%0d beats=%0d required 1/8", obs_id, q_d.size()); end
  endtask

  task automatic test_protocol_errors();
    do_reset();
    i_arvalid = 1; i_burst = 0; i_araddr = 32'h0000_0100;
    axi_serve(0, 1, 0, 1, 0, 0);
    i_arvalid = 0;
    checks++; if (qdiff(q_i, sent) != 0) begin errors++; $display("FAIL rid_still_routed: got %0d beats required 1", q_i.size()); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rid_err: got %b required 1", proto_err); end
    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_rst: got %b required 0", proto_err); end
    d_arvalid = 1; d_burst = 0; d_araddr = 32'h0000_0200;
    axi_serve(0, 2, 1, 0, 0, 0);
    d_arvalid = 0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL missing_rlast_err: got %b required 1", proto_err); end
  endtask

  task automatic test_random();
    bit pend_i, pend_d;
    int exp, t0, len;
    logic [31:0] exp_addr;
    do_reset();
    pend_i = 0; pend_d = 0;
    for (int t = 0; t < 40; t++) begin
      if (!pend_i && $urandom_range(1) == 1) begin pend_i = 1; i_araddr = $urandom; i_burst = $urandom_range(1); end
      if (!pend_d && $urandom_range(1) == 1) begin pend_d = 1; d_araddr = $urandom; d_burst = $urandom_range(1); end
      if (!pend_i && !pend_d) begin pend_i = 1; i_araddr = $urandom; i_burst = 1; end
      i_arvalid = pend_i; d_arvalid = pend_d;
      exp = pick(pend_i, pend_d);
      last_gnt = exp;
      len = (exp == 0) ? (i_burst ? 7 : 0) : (d_burst ? 7 : 0);
      exp_addr = (exp == 0) ? i_araddr : d_araddr;
      t0 = cyc;
      axi_serve($urandom_range(3), len + 1, len, 0, 1, 0);
      checks++; if (obs_arv_cyc !== t0 + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d required 1", t, obs_arv_cyc - t0); end
      checks++; if ({obs_id, obs_len, obs_addr} !== {4'(exp), 8'(len), exp_addr}) begin errors++; $display("FAIL rnd_ar[%0d]: got id=%0d len=%0d addr=%h required %0d/%0d/%h", t, obs_id, obs_len, obs_addr, exp, len, exp_addr); end
      checks++; if ({obs_irdy, obs_drdy} !== ((exp == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_arready[%0d]: got %b required side %0d", t, {obs_irdy, obs_drdy}, exp); end
      if (exp == 0) begin
        checks++; if (qdiff(q_i, sent) != 0 || q_d.size() != 0 || i_last_idx !== len) begin errors++; $display("FAIL rnd_route_i[%0d]: got i=%0d d=%0d last=%0d required %0d/0/%0d", t, q_i.size(), q_d.size(), i_last_idx, len + 1, len); end
        pend_i = 0; i_arvalid = 0;
      end else begin
        checks++; if (qdiff(q_d, sent) != 0 || q_i.size() != 0 || d_last_idx !== len) begin errors++; $display("FAIL rnd_route_d[%0d]: got d=%0d i=%0d last=%0d required %0d/0/%0d", t, q_d.size(), q_i.size(), d_last_idx, len + 1, len); end
        pend_d = 0; d_arvalid = 0;
      end
    end
    i_arvalid = 0; d_arvalid = 0;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rnd_proto_err: got %b required 0", proto_err); end
  endtask

  initial begin
    rst = 1'b1;
    i_arvalid = 0; d_arvalid = 0; i_burst = 0; d_burst = 0; i_araddr = 0; d_araddr = 0;
    i_rready = 1; d_rready = 1; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_simultaneous();
    test_fairness();
    test_uncached();
    test_backpressure_err();
    test_reset_mid_burst();
    test_protocol_errors();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_axi_read_arbiter.md
Name: cache_axi_read_arbiter

Overview:
Shares one AXI4 read port (AR and R channels) between the instruction cache and the data cache miss/uncached paths. It accepts at most one outstanding read transaction. It arbitrates round-robin, registers the winning address and burst type, issues the AR beat, then steers every R beat to the granted cache until RLAST. It sits between both caches' master-side read ports and the CPU-top AXI interface.

Parameters:
LINE_BEATS, 8, beats per cached line fill; m_arlen = LINE_BEATS-1 for bursts.
ID_INST, 4'd0, ARID used for instruction-cache transactions.
ID_DATA, 4'd1, ARID used for data-cache transactions.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
i_araddr  in  32  inst cache read address
i_arvalid  in  1  inst cache read request, held until i_arready
i_burst  in  1  1 = cached line fill (LINE_BEATS beats), 0 = single-beat uncached
i_arready  out  1  address accepted for inst cache
i_rdata  out  32  read data to inst cache
i_rvalid  out  1  data beat valid for inst cache
i_rlast  out  1  last beat for inst cache
i_rready  in  1  inst cache can take a beat
d_araddr, d_arvalid, d_burst, d_arready, d_rdata, d_rvalid, d_rlast, d_rready  same widths/directions/meaning as i_*, for the data cache
m_araddr  out  32  AXI ARADDR
m_arid  out  4  AXI ARID
m_arlen  out  8  AXI ARLEN
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  AXI ARVALID
m_arready  in  1  AXI ARREADY
m_rdata  in  32  AXI RDATA
m_rid  in  4  AXI RID
m_rlast  in  1  AXI RLAST
m_rvalid  in  1  AXI RVALID
m_rready  out  1  AXI RREADY
proto_err  out  1  sticky: RLAST/beat-count mismatch or RID mismatch

Behaviour:
- Reset is synchronous and active-high on rst; there is one clock, clk.
- State machine has three states: IDLE, ADDR, DATA.
- Reset forces: state=IDLE, grant=0, last_grant=DATA (so the first tie goes to inst), beat_cnt=0, proto_err=0.
- Reset output values: m_arvalid=0, i_/d_arready=0, i_/d_rvalid=0, i_/d_rlast=0, m_rready=1.
- IDLE, request on only one side: grant that side.
- IDLE, requests on both sides: grant the side opposite last_grant.
- On a grant: latch addr, burst, and grant, update last_grant, go to ADDR. Nothing is driven on AXI in this cycle.
- Request-to-m_arvalid latency is exactly 1 cycle.
- ADDR: m_arvalid=1 with the latched m_araddr.
  - m_arid = ID_INST or ID_DATA according to grant.
  - m_arlen = burst ? LINE_BEATS-1 : 0.
  - m_araddr is passed through unmodified; line alignment is the cache's job.
- ADDR handshake: on m_arvalid&m_arready, the granted x_arready=1 for that cycle only (combinational from m_arready), beat_cnt is cleared, next state is DATA. m_arvalid stays high until the handshake.
- If the requester drops arvalid while in ADDR, the transaction still completes, because the address is already latched.
- DATA, routing to the granted side:
  - x_rdata = m_rdata, x_rvalid = m_rvalid, x_rlast = m_rlast, m_rready = x_rready.
  - The non-granted side sees rvalid=0 and rlast=0. Its arready stays 0, and its request simply waits.
- DATA, on each m_rvalid&m_rready: beat_cnt increments (8-bit, wraps, no saturation).
- DATA, beat with m_rlast=1: next state is IDLE.
- Beat-count check: proto_err is set if m_rlast=1 while beat_cnt != latched arlen, or if m_rlast=0 while beat_cnt == arlen.
- RID check: proto_err is set if m_rid differs from m_arid on any accepted beat. The beat is still routed to the granted side.
- Back-to-back requests: re-arbitration happens in the IDLE cycle following the RLAST beat. m_arvalid therefore reasserts 2 cycles after the RLAST beat at the earliest.
- IDLE draining: m_rready=1 and neither cache sees rvalid, so stale beats (e.g. after reset mid-burst) are silently drained.
- Reset mid-operation: it returns to IDLE on the next edge, and the aborted transaction is never reported to either cache.
- Simultaneous request and RLAST: a request arriving in the same cycle as RLAST is arbitrated in the next (IDLE) cycle; it is not lost.

Test Plan:
- Single inst burst: i_arvalid=1, i_burst=1, i_araddr=0xBFC0_0000 at cycle 0 -> m_arvalid=1 at cycle 1 with m_arlen=7, m_arid=0. With m_arready=1 at cycle 1, i_arready pulses at cycle 1. Eight beats 0x11..0x88 arrive on i_rdata with i_rlast on the 8th; d_rvalid stays 0; proto_err=0.
- Simultaneous requests from reset: i and d both request at cycle 0 -> inst is granted first; data gets m_arvalid exactly 2 cycles after inst's RLAST, with m_arid=1.
- Fairness: both sides hold requests continuously for 4 transactions -> grant order is I,D,I,D.
- Uncached single read: d_burst=0, d_araddr=0xBFAF_F000 -> m_arlen=0; one beat with RLAST delivered to the d side.
- Backpressure and protocol error:
  - Hold m_arready=0 for 5 cycles -> m_arvalid and m_araddr stay stable, i_arready stays 0.
  - Then, in DATA, drive RLAST on beat 3 of a 7-length burst -> proto_err=1 and stays set until rst.
- Reset mid-burst: assert rst after beat 4 -> next cycle all outputs are at reset values. The remaining 4 beats, fed with m_rvalid=1, are drained (m_rready=1) and never appear on i_rvalid.
